// File: rtl/dir_button_conditioner_if.sv
// Direction-button bundle: raw pushbutton levels in, conditioned direction pulses out.
interface dir_button_conditioner_if;
   logic btn_n, btn_s, btn_e, btn_w;
   logic n, s, e, w;
   logic conflict;

   modport master (
      output btn_n, btn_s, btn_e, btn_w,
      input  n, s, e, w, conflict
   );

   modport slave (
      input  btn_n, btn_s, btn_e, btn_w,
      output n, s, e, w, conflict
   );
endinterface

// File: rtl/dir_button_conditioner.sv
// Synchronizes and debounces four direction buttons, then emits one-cycle direction
// pulses on clean presses or a conflict pulse on ambiguous ones.
module dir_button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   dir_button_conditioner_if.slave   bus
);

   localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Channel index order throughout: 0 = n, 1 = s, 2 = e, 3 = w.
   logic [3:0]       btn;
   logic [3:0]       sync1, sync2;
   logic [3:0]       deb, deb_d, deb_nxt;
   logic [CNT_W-1:0] cnt     [4];
   logic [CNT_W-1:0] cnt_nxt [4];
   logic [3:0]       rise;
   logic [3:0]       dir, dir_nxt;
   logic             conflict_q, conflict_nxt;

   function automatic logic onehot4(input logic [3:0] v);
      return (v != 4'b0) && ((v & (v - 4'd1)) == 4'b0);
   endfunction

   assign btn = {bus.btn_w, bus.btn_e, bus.btn_s, bus.btn_n};

   // Debounce stage: accept a new level only after a full run of mismatching samples.
   always_comb begin
      deb_nxt = deb;
      for (int i = 0; i < 4; i++) begin
         cnt_nxt[i] = '0;
         if (sync2[i] != deb[i]) begin
            if (cnt[i] == CNT_MAX) begin
               deb_nxt[i] = sync2[i];
            end else begin
               cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Pulse stage: a lone rise with every other level low is a move, anything else is a conflict.
   assign rise = deb & ~deb_d;

   always_comb begin
      dir_nxt      = '0;
      conflict_nxt = 1'b0;
      if (rise != 4'b0) begin
         if (onehot4(rise) && ((deb & ~rise) == 4'b0)) begin
            dir_nxt = rise;
         end else begin
            conflict_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1      <= '0;
         sync2      <= '0;
         deb        <= '0;
         deb_d      <= '0;
         dir        <= '0;
         conflict_q <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync1      <= btn;
         sync2      <= sync1;
         deb        <= deb_nxt;
         deb_d      <= deb;
         dir        <= dir_nxt;
         conflict_q <= conflict_nxt;
         for (int i = 0; i < 4; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
      end
   end

   assign bus.n        = dir[0];
   assign bus.s        = dir[1];
   assign bus.e        = dir[2];
   assign bus.w        = dir[3];
   assign bus.conflict = conflict_q;

endmodule

// File: tb/tb_dir_button_conditioner.sv
// Scoreboard bench for dir_button_conditioner: a sliding-window reference model predicts
// pulses, a negedge monitor checks them, and directed scenarios check exact timing.
`timescale 1ns/1ps
module tb_dir_button_conditioner;

   localparam int D = 4;
   localparam logic [4:0] C_N = 5'b00001;
   localparam logic [4:0] C_S = 5'b00010;
   localparam logic [4:0] C_E = 5'b00100;
   localparam logic [4:0] C_W = 5'b01000;
   localparam logic [4:0] C_C = 5'b10000;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   dir_button_conditioner_if bus ();

   dir_button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #50 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [4:0] code;
   } ev_t;

   ev_t exp_q[$];
   ev_t obs_q[$];
   ev_t dexp_q[$];
   int  checks = 0;
   int  fails = 0;
   int  edge_cnt = 0;

   // Reference model: a level flips once the last D synchronized samples all disagree with it.
   bit lvl[4];
   bit rise_p[4];
   bit raw_h[4][$];
   bit s_h[4][$];

   always @(posedge clk) begin
      logic [3:0] b;
      int         nr, ri;
      bit         others, smp, all_diff;
      ev_t        ev;
      edge_cnt++;
      b = {bus.btn_w, bus.btn_e, bus.btn_s, bus.btn_n};
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) begin
            lvl[i] = 1'b0;
            rise_p[i] = 1'b0;
            raw_h[i].delete();
            s_h[i].delete();
         end
      end else begin
         nr = 0;
         ri = 0;
         for (int i = 0; i < 4; i++) begin
            if (rise_p[i]) begin
               nr++;
               ri = i;
            end
         end
         others = 1'b0;
         for (int i = 0; i < 4; i++) begin
            if (i != ri && lvl[i]) others = 1'b1;
         end
         ev.cyc = edge_cnt;
         if (nr == 1 && !others) begin
            ev.code = 5'(1 << ri);
            exp_q.push_back(ev);
         end else if (nr > 0) begin
            ev.code = C_C;
            exp_q.push_back(ev);
         end
         for (int i = 0; i < 4; i++) begin
            smp = (raw_h[i].size() >= 2) ? raw_h[i][raw_h[i].size() - 2] : 1'b0;
            raw_h[i].push_back(b[i]);
            if (raw_h[i].size() > 2) void'(raw_h[i].pop_front());
            s_h[i].push_back(smp);
            if (s_h[i].size() > D) void'(s_h[i].pop_front());
            rise_p[i] = 1'b0;
            if (s_h[i].size() >= D) begin
               all_diff = 1'b1;
               for (int k = 0; k < D; k++) begin
                  if (s_h[i][s_h[i].size() - 1 - k] == lvl[i]) all_diff = 1'b0;
               end
               if (all_diff) begin
                  rise_p[i] = !lvl[i];
                  lvl[i] = !lvl[i];
                  s_h[i].delete();
               end
            end
         end
      end
   end

   // A reset kills any pulse that was about to be presented.
   always @(negedge reset_n) exp_q.delete();

   always @(negedge clk) begin
      logic [4:0] got;
      ev_t        ev;
      got = {bus.conflict, bus.w, bus.e, bus.s, bus.n};
      if (!reset_n) begin
         checks++;
         if (got != 5'b0) begin
            fails++;
            $display("FAIL reset_outputs: edge %0d got %b, required 00000", edge_cnt, got);
         end
      end else begin
         while (exp_q.size() > 0 && exp_q[0].cyc < edge_cnt) begin
            checks++;
            fails++;
            $display("FAIL missing_pulse: edge %0d code %b never seen, required it", exp_q[0].cyc, exp_q[0].code);
            void'(exp_q.pop_front());
         end
         if (got != 5'b0) begin
            ev.cyc = edge_cnt;
            ev.code = got;
            obs_q.push_back(ev);
            checks++;
            if (exp_q.size() == 0 || exp_q[0].cyc != edge_cnt) begin
               fails++;
               $display("FAIL unexpected_output: edge %0d got %b, required 00000", edge_cnt, got);
            end else begin
               if (got != exp_q[0].code) begin
                  fails++;
                  $display("FAIL pulse_code: edge %0d got %b, required %b", edge_cnt, got, exp_q[0].code);
               end
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #10;
   endtask

   task automatic chk(input string name, input logic [4:0] got, input logic [4:0] req);
      checks++;
      if (got !== req) begin
         fails++;
         $display("FAIL %s: got %b, required %b", name, got, req);
      end
   endtask

   function automatic logic [4:0] outs();
      return {bus.conflict, bus.w, bus.e, bus.s, bus.n};
   endfunction

   task automatic dpush(input int cyc, input logic [4:0] code);
      ev_t ev;
      ev.cyc = cyc;
      ev.code = code;
      dexp_q.push_back(ev);
   endtask

   task automatic check_log(input string name);
      checks++;
      if (obs_q.size() != dexp_q.size()) begin
         fails++;
         $display("FAIL %s_count: got %0d events, required %0d", name, obs_q.size(), dexp_q.size());
      end else begin
         for (int i = 0; i < dexp_q.size(); i++) begin
            checks++;
            if (obs_q[i].cyc != dexp_q[i].cyc || obs_q[i].code != dexp_q[i].code) begin
               fails++;
               $display("FAIL %s_event%0d: got edge %0d code %b, required edge %0d code %b",
                        name, i, obs_q[i].cyc, obs_q[i].code, dexp_q[i].cyc, dexp_q[i].code);
            end
         end
      end
      obs_q.delete();
      dexp_q.delete();
   endtask

   task automatic set_btns(input logic [3:0] v);
      {bus.btn_w, bus.btn_e, bus.btn_s, bus.btn_n} = v;
   endtask

   initial begin
      int s0, s1;
      logic [3:0] game[5];
      logic [4:0] gcode[5];
      set_btns(4'b0000);
      reset_n = 1'b0;
      step(3);
      chk("reset_state", outs(), 5'b0);
      reset_n = 1'b1;
      step(3);
      obs_q.delete();

      // Clean press on e
      s0 = edge_cnt + 1;
      bus.btn_e = 1'b1;
      dpush(s0 + 6, C_E);
      step(10);
      bus.btn_e = 1'b0;
      step(12);
      check_log("clean_press");

      // Three-cycle glitch on n
      bus.btn_n = 1'b1;
      step(3);
      bus.btn_n = 1'b0;
      step(20);
      check_log("glitch");

      // Bounce on s, then steady high
      s0 = edge_cnt + 1;
      for (int k = 0; k < 6; k++) begin
         bus.btn_s = (k % 2 == 0);
         step(1);
      end
      bus.btn_s = 1'b1;
      dpush(s0 + 12, C_S);
      step(12);
      bus.btn_s = 1'b0;
      step(12);
      check_log("bounce");

      // Simultaneous s and e
      s0 = edge_cnt + 1;
      set_btns(4'b0110);
      dpush(s0 + 6, C_C);
      step(10);
      set_btns(4'b0000);
      step(12);
      check_log("simultaneous");

      // Overlap: w held, n pressed later, then a clean n
      s0 = edge_cnt + 1;
      bus.btn_w = 1'b1;
      dpush(s0 + 6, C_W);
      step(8);
      bus.btn_n = 1'b1;
      dpush(s0 + 14, C_C);
      step(10);
      set_btns(4'b0000);
      step(12);
      s1 = edge_cnt + 1;
      bus.btn_n = 1'b1;
      dpush(s1 + 6, C_N);
      step(10);
      bus.btn_n = 1'b0;
      step(12);
      check_log("overlap");

      // Reset mid-debounce with e held throughout
      s0 = edge_cnt + 1;
      bus.btn_e = 1'b1;
      step(4);
      reset_n = 1'b0;
      #1;
      chk("reset_mid_debounce", outs(), 5'b0);
      step(2);
      reset_n = 1'b1;
      dpush(s0 + 12, C_E);
      step(10);
      bus.btn_e = 1'b0;
      step(12);
      check_log("reset_debounce");

      // Reset while the n pulse is on the output; held n pulses again after release
      s0 = edge_cnt + 1;
      bus.btn_n = 1'b1;
      step(7);
      chk("pulse_before_reset", outs(), C_N);
      reset_n = 1'b0;
      #1;
      chk("reset_mid_pulse", outs(), 5'b0);
      step(2);
      reset_n = 1'b1;
      dpush(s0 + 15, C_N);
      step(10);
      bus.btn_n = 1'b0;
      step(12);
      check_log("reset_pulse");

      // Game sequence e, s, w, e, e
      game  = '{4'b0100, 4'b0010, 4'b1000, 4'b0100, 4'b0100};
      gcode = '{C_E, C_S, C_W, C_E, C_E};
      for (int g = 0; g < 5; g++) begin
         s0 = edge_cnt + 1;
         set_btns(game[g]);
         dpush(s0 + 6, gcode[g]);
         step(8);
         set_btns(4'b0000);
         step(8);
      end
      step(8);
      check_log("game");

      // Randomized traffic against the model, with occasional resets
      for (int it = 0; it < 400; it++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 4) set_btns(4'b0000);
         else if (r < 8) set_btns(4'(1 << $urandom_range(0, 3)));
         else set_btns(4'($urandom_range(0, 15)));
         if ($urandom_range(0, 39) == 0) begin
            reset_n = 1'b0;
            step($urandom_range(1, 2));
            reset_n = 1'b1;
         end
         step($urandom_range(1, 10));
      end
      set_btns(4'b0000);
      step(30);
      while (exp_q.size() > 0) begin
         checks++;
         fails++;
         $display("FAIL missing_pulse_end: edge %0d code %b never seen, required it", exp_q[0].cyc, exp_q[0].code);
         void'(exp_q.pop_front());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/dir_button_conditioner.md
DIR_BUTTON_CONDITIONER -- requirements
Module: dir_button_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized cycles needed to accept a level change; legal range 2..65535.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 btn_n, btn_s, btn_e, btn_w  input  1 each  raw, asynchronous, bouncy pushbutton levels; 1 = pressed.
REQ-005 n, s, e, w  output  1 each  registered one-cycle direction pulses that feed the adventure game's n/s/e/w inputs.
REQ-006 conflict  output  1  registered one-cycle pulse flagging a rejected ambiguous press.

Function
REQ-007 Each btn_x SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other logic uses it.
REQ-008 Each channel SHALL hold a debounced level deb_x and an unsigned counter cnt_x of width clog2(DEBOUNCE_CYCLES).
REQ-009 Counter rules when sync2_x == deb_x: cnt_x <= 0.
REQ-010 Counter rules when sync2_x != deb_x and cnt_x < DEBOUNCE_CYCLES-1: cnt_x <= cnt_x+1.
REQ-011 When sync2_x != deb_x and cnt_x == DEBOUNCE_CYCLES-1, the block SHALL set deb_x <= sync2_x and cnt_x <= 0.
REQ-012 Any mismatch run shorter than DEBOUNCE_CYCLES cycles SHALL leave deb_x unchanged, so glitches and bounces are rejected.
REQ-013 A rise_x event SHALL be the cycle in which deb_x changes 0->1; a 1->0 change SHALL generate no output.
REQ-014 Pulse rule: if exactly one rise_x occurs in a cycle and the other three deb levels are 0 after that update, output x SHALL be 1 for exactly the next cycle.
REQ-015 Conflict rule: if two or more rise events occur in the same cycle, or a rise_x occurs while another deb_y is 1, no direction pulse SHALL be issued and conflict SHALL be 1 for exactly the next cycle.
REQ-016 At most one of n/s/e/w SHALL be 1 in any cycle, and a direction pulse and conflict SHALL never be 1 together.
REQ-017 Latency: with btn_x sampled 1 at edge 0 and held, deb_x SHALL rise at edge DEBOUNCE_CYCLES+1 and pulse x SHALL be high from edge DEBOUNCE_CYCLES+2 to edge DEBOUNCE_CYCLES+3.
REQ-018 A held button SHALL produce exactly one pulse per press, with no auto-repeat.
REQ-019 A new pulse on the same button SHALL require deb_x to return to 0 and then rise again.
REQ-020 Releasing one button while another is held SHALL NOT generate a pulse for the held button.

Reset
REQ-021 While reset_n = 0, the following SHALL all be 0 immediately and asynchronously: n, s, e, w, conflict, every sync flop, every deb_x and every cnt_x.
REQ-022 Reset deassertion SHALL be synchronous-safe: the first state update occurs at the first rising edge of clk with reset_n = 1.
REQ-023 A button already pressed at reset release SHALL be debounced from zero and SHALL pulse per REQ-017, counted from the first post-reset sampling edge.
REQ-024 Reset asserted mid-debounce or mid-pulse SHALL abort that pulse, and no stale pulse SHALL appear after release.

Verification (DEBOUNCE_CYCLES = 4, 100 ns clock, inputs changed 10 ns after the edge)
REQ-025 Clean press: reset, then btn_e held high 10 cycles -> e = 1 for exactly one cycle starting edge 6 after first sample; n, s, w and conflict stay 0.
REQ-026 Glitch: btn_n high for 3 cycles then low -> no pulse on any output for 20 cycles.
REQ-027 Bounce: btn_s toggles every cycle for 6 cycles, then held high -> exactly one s pulse, 6 edges after the first edge of the steady-high run.
REQ-028 Simultaneous press: btn_s and btn_e rise on the same sample and are held -> conflict = 1 for one cycle at edge 6; s and e never assert.
REQ-029 Overlap: btn_w held, btn_n pressed 8 cycles later while w is still held -> w pulse at edge 6, then conflict pulse and no n pulse; after both are released, a clean btn_n press -> n pulse.
REQ-030 Reset mid-operation: btn_e held, reset_n pulled low at edge 3 for 2 cycles and then released, btn_e still held -> all outputs 0 during reset; one e pulse 6 edges after the first post-reset sample.
REQ-031 Game sequence: presses e, s, w, e, e, each held 8 cycles with 8 idle cycles between -> exactly five pulses in the order e, s, w, e, e, and conflict never asserts.
